// File: rtl/mem_wb_skid_stage_if.sv
// mem_wb_skid_stage_if: upstream/downstream handshake and entry fields of the MEM/WB stage.
interface mem_wb_skid_stage_if #(
    parameter int XLEN      = 32,
    parameter int PAYLOAD_W = 96,
    parameter int RD_W      = 5
);
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [XLEN-1:0]      in_pc;
    logic [31:0]          in_inst;
    logic [RD_W-1:0]      in_rd;
    logic                 in_wb_en;
    logic [1:0]           in_wb_sel;
    logic [PAYLOAD_W-1:0] in_payload;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_pc;
    logic [XLEN-1:0]      out_pc_next;
    logic [31:0]          out_inst;
    logic [RD_W-1:0]      out_rd;
    logic                 out_wb_en;
    logic [1:0]           out_wb_sel;
    logic [PAYLOAD_W-1:0] out_payload;
    modport slave (
        input  flush, in_valid, in_pc, in_inst, in_rd, in_wb_en, in_wb_sel, in_payload, out_ready,
        output in_ready, out_valid, out_pc, out_pc_next, out_inst, out_rd, out_wb_en, out_wb_sel, out_payload
    );
    modport master (
        output flush, in_valid, in_pc, in_inst, in_rd, in_wb_en, in_wb_sel, in_payload, out_ready,
        input  in_ready, out_valid, out_pc, out_pc_next, out_inst, out_rd, out_wb_en, out_wb_sel, out_payload
    );
endinterface

// File: rtl/mem_wb_skid_stage.sv
// mem_wb_skid_stage: MEM/WB boundary register with 2-entry skid buffer, flush and retire/stall counters.
module mem_wb_skid_stage #(
    parameter int XLEN      = 32,
    parameter int PAYLOAD_W = 96,
    parameter int RD_W      = 5,
    parameter int PC_INC    = 4,
    parameter int CNT_W     = 32
) (
    input  logic                 cpu_clk,
    input  logic                 reset_n,
    mem_wb_skid_stage_if.slave   bus,
    output logic [CNT_W-1:0]     retire_cnt,
    output logic [CNT_W-1:0]     stall_cnt
);
    localparam int E_W = XLEN + 32 + RD_W + 1 + 2 + PAYLOAD_W;
    logic [E_W-1:0]   main_q, main_d, skid_q, skid_d, in_e;
    logic             main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic [CNT_W-1:0] retire_q, retire_d, stall_q, stall_d;
    logic             in_xfer, out_xfer, pop_skid, load_main, load_skid, held_wb_en;
    assign in_e = {bus.in_pc, bus.in_inst, bus.in_rd, bus.in_wb_en, bus.in_wb_sel, bus.in_payload};
    assign {bus.out_pc, bus.out_inst, bus.out_rd, held_wb_en, bus.out_wb_sel, bus.out_payload} = main_q;
    assign bus.in_ready    = !skid_valid_q;
    assign bus.out_valid   = main_valid_q;
    assign bus.out_wb_en   = held_wb_en & main_valid_q;
    assign bus.out_pc_next = bus.out_pc + XLEN'(PC_INC);
    assign retire_cnt      = retire_q;
    assign stall_cnt       = stall_q;
    // Flush wins: data registers hold their stale contents, only valid bits drop.
    always_comb begin
        in_xfer      = bus.in_valid & !skid_valid_q;
        out_xfer     = main_valid_q & bus.out_ready;
        pop_skid     = !bus.flush & out_xfer & skid_valid_q;
        load_main    = !bus.flush & in_xfer & (!main_valid_q | out_xfer);
        load_skid    = !bus.flush & in_xfer & main_valid_q & !out_xfer;
        main_d       = pop_skid ? skid_q : load_main ? in_e : main_q;
        skid_d       = load_skid ? in_e : skid_q;
        main_valid_d = !bus.flush & (pop_skid | load_main | (main_valid_q & !out_xfer));
        skid_valid_d = !bus.flush & (load_skid | (skid_valid_q & !out_xfer));
        retire_d     = retire_q + CNT_W'(out_xfer & ~&retire_q);
        stall_d      = stall_q + CNT_W'(main_valid_q & !bus.out_ready & ~&stall_q);
    end
    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            retire_q     <= '0;
            stall_q      <= '0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            retire_q     <= retire_d;
            stall_q      <= stall_d;
        end
    end
endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// tb_mem_wb_skid_stage: vector table, corner sequences and random traffic against a queue model.
module tb_mem_wb_skid_stage;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic        we;
        logic [1:0]  sel;
        logic [95:0] pl;
    } ent_t;
    typedef struct {
        logic        iv;
        logic        ordy;
        logic [31:0] pc;
        logic        exp_ov;
        logic        exp_ir;
        logic [31:0] exp_pc;
    } vec_t;
    logic cpu_clk = 1'b0;
    logic reset_n = 1'b0;
    logic [CNT_W-1:0] retire_cnt, stall_cnt;
    int checks = 0;
    int failures = 0;
    ent_t mq[$];
    int m_ret = 0;
    int m_stall = 0;
    vec_t tbl[11];
    always #5 cpu_clk = ~cpu_clk;
    mem_wb_skid_stage_if #(.XLEN(32), .PAYLOAD_W(96), .RD_W(5)) bus ();
    mem_wb_skid_stage #(.XLEN(32), .PAYLOAD_W(96), .RD_W(5), .PC_INC(4), .CNT_W(CNT_W)) dut (
        .cpu_clk(cpu_clk), .reset_n(reset_n), .bus(bus), .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
    );
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask
    task automatic compare_model();
        chk("out_valid", bus.out_valid, mq.size() > 0);
        chk("in_ready", bus.in_ready, mq.size() < 2);
        chk("out_wb_en", bus.out_wb_en, mq.size() > 0 && mq[0].we);
        chk("retire_cnt", retire_cnt, m_ret);
        chk("stall_cnt", stall_cnt, m_stall);
        if (mq.size() > 0) begin
            chk("out_pc", bus.out_pc, mq[0].pc);
            chk("out_pc_next", bus.out_pc_next, 32'(mq[0].pc + 32'd4));
            chk("out_inst", bus.out_inst, mq[0].inst);
            chk("out_rd", bus.out_rd, mq[0].rd);
            chk("out_wb_sel", bus.out_wb_sel, mq[0].sel);
            chk("out_payload", bus.out_payload, mq[0].pl);
        end
    endtask
    // Called at a falling edge; returns at the next falling edge after checking the model.
    task automatic step(input logic iv, input logic ordy, input logic fl, input logic [31:0] pc, input logic we);
        ent_t e;
        bit ix, ox, st;
        e.pc = pc;
        e.inst = $urandom;
        e.rd = 5'($urandom);
        e.we = we;
        e.sel = 2'($urandom);
        e.pl = {$urandom, $urandom, $urandom};
        bus.in_valid = iv;
        bus.out_ready = ordy;
        bus.flush = fl;
        bus.in_pc = e.pc;
        bus.in_inst = e.inst;
        bus.in_rd = e.rd;
        bus.in_wb_en = e.we;
        bus.in_wb_sel = e.sel;
        bus.in_payload = e.pl;
        ix = iv && mq.size() < 2;
        ox = mq.size() > 0 && ordy;
        st = mq.size() > 0 && !ordy;
        @(posedge cpu_clk);
        if (ox && m_ret < CMAX) m_ret++;
        if (st && m_stall < CMAX) m_stall++;
        if (fl) mq.delete();
        else begin
            if (ox) void'(mq.pop_front());
            if (ix) mq.push_back(e);
        end
        @(negedge cpu_clk);
        compare_model();
    endtask
    task automatic do_reset();
        reset_n = 1'b0;
        mq.delete();
        m_ret = 0;
        m_stall = 0;
        @(negedge cpu_clk);
        reset_n = 1'b1;
    endtask
    initial begin
        tbl[0]  = '{1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 32'h100};
        tbl[1]  = '{1'b1, 1'b1, 32'h104, 1'b1, 1'b1, 32'h104};
        tbl[2]  = '{1'b1, 1'b1, 32'h108, 1'b1, 1'b1, 32'h108};
        tbl[3]  = '{1'b1, 1'b1, 32'h10C, 1'b1, 1'b1, 32'h10C};
        tbl[4]  = '{1'b0, 1'b1, 32'h0,   1'b0, 1'b1, 32'h10C};
        tbl[5]  = '{1'b1, 1'b0, 32'h200, 1'b1, 1'b1, 32'h200};
        tbl[6]  = '{1'b1, 1'b0, 32'h204, 1'b1, 1'b0, 32'h200};
        tbl[7]  = '{1'b1, 1'b0, 32'h208, 1'b1, 1'b0, 32'h200};
        tbl[8]  = '{1'b1, 1'b1, 32'h208, 1'b1, 1'b1, 32'h204};
        tbl[9]  = '{1'b1, 1'b1, 32'h208, 1'b1, 1'b1, 32'h208};
        tbl[10] = '{1'b0, 1'b1, 32'h0,   1'b0, 1'b1, 32'h208};
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_pc = '0;
        bus.in_inst = '0;
        bus.in_rd = '0;
        bus.in_wb_en = 1'b0;
        bus.in_wb_sel = '0;
        bus.in_payload = '0;
        #1;
        chk("rst out_valid", bus.out_valid, 1'b0);
        chk("rst in_ready", bus.in_ready, 1'b1);
        chk("rst out_wb_en", bus.out_wb_en, 1'b0);
        chk("rst out_pc_next", bus.out_pc_next, 32'h4);
        chk("rst retire_cnt", retire_cnt, 0);
        @(negedge cpu_clk);
        reset_n = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].iv, tbl[i].ordy, 1'b0, tbl[i].pc, 1'b1);
            chk($sformatf("vec%0d out_valid", i), bus.out_valid, tbl[i].exp_ov);
            chk($sformatf("vec%0d in_ready", i), bus.in_ready, tbl[i].exp_ir);
            chk($sformatf("vec%0d out_pc", i), bus.out_pc, tbl[i].exp_pc);
            if (i == 4) begin
                chk("stream retire_cnt", retire_cnt, 4);
                chk("stream stall_cnt", stall_cnt, 0);
            end
        end
        chk("bp stall_cnt", stall_cnt, 2);
        chk("bp retire_cnt", retire_cnt, 7);
        step(1'b1, 1'b0, 1'b0, 32'h300, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h304, 1'b1);
        chk("pre-flush in_ready", bus.in_ready, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h308, 1'b1);
        chk("flush out_valid", bus.out_valid, 1'b0);
        chk("flush out_wb_en", bus.out_wb_en, 1'b0);
        chk("flush in_ready", bus.in_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            chk("post-flush out_valid", bus.out_valid, 1'b0);
        end
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 32'h1000 + 32'(4 * i), 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 1'b1);
        chk("sat retire_cnt", retire_cnt, 15);
        chk("wrap out_pc_next", bus.out_pc_next, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        do_reset();
        step(1'b1, 1'b0, 1'b0, 32'h500, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h504, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("pre-areset stall_cnt", stall_cnt, 7);
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset out_valid", bus.out_valid, 1'b0);
        chk("areset in_ready", bus.in_ready, 1'b1);
        chk("areset out_wb_en", bus.out_wb_en, 1'b0);
        chk("areset stall_cnt", stall_cnt, 0);
        chk("areset retire_cnt", retire_cnt, 0);
        do_reset();
        step(1'b1, 1'b1, 1'b0, 32'h400, 1'b1);
        chk("gate wb_en on", bus.out_wb_en, 1'b1);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("gate wb_en off", bus.out_wb_en, 1'b0);
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0), $urandom_range(0, 15) == 0,
                 $urandom, 1'($urandom_range(0, 1)));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_wb_skid_stage.md
Name: mem_wb_skid_stage

Overview:
Parametrised MEM/WB pipeline boundary register for the tracer core. It replaces the plain enable-gated stage register with a valid/ready handshake and a 2-entry skid buffer, so backpressure from writeback/trace never drops an instruction. It adds flush, a next-PC adder and retire/stall performance counters. It sits between the memory stage and writeback/trace capture.

Parameters:
XLEN, 32, width of PC and data fields
PAYLOAD_W, 96, width of opaque side-band payload (ALU result, mem data, etc.)
RD_W, 5, destination register index width
PC_INC, 4, increment added to PC to form out_pc_next
CNT_W, 32, width of performance counters

Ports:
cpu_clk  in  1  clock, all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
flush  in  1  discard all held and incoming entries this cycle
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept an entry
in_pc  in  XLEN  PC of incoming instruction
in_inst  in  32  instruction word
in_rd  in  RD_W  destination register
in_wb_en  in  1  register writeback enable
in_wb_sel  in  2  writeback source select
in_payload  in  PAYLOAD_W  side-band data
out_valid  out  1  output entry valid
out_ready  in  1  downstream accepts entry
out_pc  out  XLEN  held PC
out_pc_next  out  XLEN  out_pc + PC_INC, modulo 2^XLEN
out_inst  out  32  held instruction
out_rd  out  RD_W  held rd
out_wb_en  out  1  held wb_en AND out_valid
out_wb_sel  out  2  held wb_sel
out_payload  out  PAYLOAD_W  held payload
retire_cnt  out  CNT_W  count of output handshakes
stall_cnt  out  CNT_W  count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Reset (reset_n=0, asynchronous): main and skid valid = 0; all data registers = 0; retire_cnt = stall_cnt = 0. Outputs: out_valid=0, out_wb_en=0, in_ready=1, out_pc_next=PC_INC.
- in_ready is driven from registered state only: in_ready = !skid_valid. There is no combinational path from out_ready.
- Input transfer: in_valid & in_ready at a clock edge. Output transfer: out_valid & out_ready.
- Storage: main register (drives outputs) and skid register. On input transfer:
  - If main is empty, or main transfers out this cycle, load main; latency is 1 cycle.
  - Otherwise, load skid.
- On output transfer with skid_valid=1: skid moves into main and skid_valid clears. A simultaneous input transfer cannot occur in this case because in_ready=0.
- On output transfer with no skid and no input transfer: main_valid clears.
- Order is preserved at all times. No entry is duplicated or dropped absent flush.
- Flush has priority over everything. At the next edge, main_valid=0 and skid_valid=0, and any input transferred in the flush cycle is discarded. in_ready=1 the cycle after. Data registers keep stale values; out_wb_en is 0 because out_valid=0.
- An output transfer in a flush cycle counts as completed: the consumer took it.
- retire_cnt increments by 1 on each output transfer. stall_cnt increments by 1 on each cycle with out_valid & !out_ready. Both counters saturate at 2^CNT_W-1 and do not wrap.
- out_pc_next is combinational from the held PC. Carry out of XLEN is dropped.
- Mid-operation reset clears valid bits and counters immediately, independent of the clock.

Test Plan:
- Streaming: out_ready=1, send 4 entries with in_pc=0x100,0x104,0x108,0x10C on back-to-back cycles -> each appears 1 cycle later in order; out_pc_next=0x104..0x110; retire_cnt=4; stall_cnt=0; in_ready stays 1.
- Backpressure: hold out_ready=0, present 3 entries -> first two accepted (main then skid), in_ready=0 on the third. stall_cnt increments each cycle. Release out_ready -> entries emerge in order, then the third is accepted; no loss.
- Flush with full skid: main and skid occupied, assert flush with in_valid=1 -> next cycle out_valid=0 and out_wb_en=0; in_ready=1; the flushed input never appears at the output.
- Wrap/saturation: CNT_W=4, 20 output handshakes -> retire_cnt holds at 15. in_pc=0xFFFFFFFC -> out_pc_next=0x00000000.
- Async reset mid-stall: main and skid full, stall_cnt=7, drop reset_n between edges -> out_valid=0, in_ready=1 and counters=0 immediately, without waiting for a clock edge.
- wb_en gating: in_wb_en=1 entry, then a bubble with in_valid=0 -> out_wb_en=1 for the entry's cycle only, then 0.
